mux_arb_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. A built-in round-robin arbiter replaces the external `sel` of the combinational mux family. It sits between several producers and one shared consumer, and moves at most one word per cycle through a single output register. The output also reports which channel the word came from.

---
 rtl/mux_arb_rr.sv | 78 +++++++
 tb/tb_mux_arb_rr.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux_arb_rr.sv
// mux_arb_rr: registered N-channel valid/ready mux with round-robin arbiter; define MUX_ARB_FIXED_PRIO_EN for fixed priority
module mux_arb_rr #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4,
    parameter int SWIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]       i_valid,
    output logic [NUM_CH-1:0]       i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [SWIDTH-1:0]       o_ch,
    output logic                    o_valid,
    input  logic                    o_ready
);
    logic [WIDTH-1:0]  o_data_q, o_data_d, sel_data;
    logic [SWIDTH-1:0] o_ch_q, o_ch_d, gidx, ptr_q;
    logic              o_valid_q, o_valid_d, found, load, xfer;
    logic [NUM_CH-1:0] gnt;
    int                idx;
`ifdef MUX_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [SWIDTH-1:0] ptr_d;
`endif
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            idx = (idx >= NUM_CH) ? idx - NUM_CH : idx;
            if (!found && i_valid[idx]) begin
                found    = 1'b1;
                gidx     = SWIDTH'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (gnt[k]) sel_data = i_data[k*WIDTH +: WIDTH];
    end
    assign load    = !o_valid_q || o_ready;
    assign xfer    = !rst && load && found;
    assign i_ready = xfer ? gnt : '0;
    always_comb begin
        o_valid_d = xfer ? 1'b1 : (o_ready ? 1'b0 : o_valid_q);
        o_data_d  = xfer ? sel_data : o_data_q;
        o_ch_d    = xfer ? gidx : o_ch_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr_d     = !xfer ? ptr_q : (gidx == SWIDTH'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_ch_q    <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_ch_q    <= o_ch_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_ch    = o_ch_q;
endmodule

// File: tb/tb_mux_arb_rr.sv
// tb_mux_arb_rr: directed self-checking bench for mux_arb_rr
module tb_mux_arb_rr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_data = 16'hDCBA;
    logic [3:0]  i_valid = 4'b0000;
    logic [3:0]  i_ready;
    logic [3:0]  o_data;
    logic [1:0]  o_ch;
    logic        o_valid;
    logic        o_ready = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    mux_arb_rr #(.WIDTH(4), .NUM_CH(4), .SWIDTH(2)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] v, input logic r);
        @(negedge clk);
        i_valid = v;
        o_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(4'b0000, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_data = 16'hDCBA;
        set_in(4'b1111, 1'b1);
        rst = 1'b1;
        #1;
        tick();
        @(negedge clk);
        n_cmp++; if (i_ready !== 4'b0000) begin n_err++; $display("FAIL rst_i_ready: got %b want 0000", i_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_data !== 4'h0) begin n_err++; $display("FAIL rst_o_data: got %h want 0", o_data); end
        n_cmp++; if (o_ch !== 2'd0) begin n_err++; $display("FAIL rst_o_ch: got %0d want 0", o_ch); end
        rst = 1'b0;
        #1;
        n_cmp++; if (i_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant: got %b want 0001", i_ready); end
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd0, 4'hA}) begin n_err++; $display("FAIL rst_first_word: got v=%b ch=%0d d=%h want v=1 ch=0 d=a", o_valid, o_ch, o_data); end
    endtask

    task automatic test_reset_mid();
        set_in(4'b1111, 1'b1);
        rst = 1'b1;
        #1;
        n_cmp++; if (i_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_i_ready: got %b want 0000", i_ready); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_o_valid: got %b want 0", o_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_contention();
        logic [3:0] exp_d;
        do_reset();
        i_data = 16'hDCBA;
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1111, 1'b1);
            n_cmp++; if (i_ready !== 4'(1 << (i % 4))) begin n_err++; $display("FAIL cont_i_ready[%0d]: got %b want %b", i, i_ready, 4'(1 << (i % 4))); end
            tick();
            exp_d = 4'(4'hA + (i % 4));
            n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'(i % 4), exp_d}) begin n_err++; $display("FAIL cont_word[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, o_valid, o_ch, o_data, i % 4, exp_d); end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [3:0] vin [4] = '{4'b1000, 4'b0010, 4'b0011, 4'b0011};
        logic [1:0] ech [4] = '{2'd3, 2'd1, 2'd0, 2'd1};
        do_reset();
        i_data = 16'hDCBA;
        for (int i = 0; i < 4; i++) begin
            set_in(vin[i], 1'b1);
            n_cmp++; if (i_ready !== 4'(1 << ech[i])) begin n_err++; $display("FAIL sparse_i_ready[%0d]: got %b want %b", i, i_ready, 4'(1 << ech[i])); end
            tick();
            n_cmp++; if ({o_valid, o_ch} !== {1'b1, ech[i]}) begin n_err++; $display("FAIL sparse_word[%0d]: got v=%b ch=%0d want v=1 ch=%0d", i, o_valid, o_ch, ech[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_data = 16'hD5BA;
        set_in(4'b0100, 1'b1);
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd2, 4'h5}) begin n_err++; $display("FAIL bp_load: got v=%b ch=%0d d=%h want v=1 ch=2 d=5", o_valid, o_ch, o_data); end
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1111, 1'b0);
            n_cmp++; if (i_ready !== 4'b0000) begin n_err++; $display("FAIL bp_i_ready[%0d]: got %b want 0000", i, i_ready); end
            tick();
            n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd2, 4'h5}) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=2 d=5", i, o_valid, o_ch, o_data); end
        end
        set_in(4'b1111, 1'b1);
        n_cmp++; if (i_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_grant: got %b want 1000", i_ready); end
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd3, 4'hD}) begin n_err++; $display("FAIL bp_release_word: got v=%b ch=%0d d=%h want v=1 ch=3 d=d", o_valid, o_ch, o_data); end
    endtask

    task automatic test_drain();
        set_in(4'b0000, 1'b1);
        n_cmp++; if (i_ready !== 4'b0000) begin n_err++; $display("FAIL drain_i_ready: got %b want 0000", i_ready); end
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b0, 2'd3, 4'hD}) begin n_err++; $display("FAIL drain_hold: got v=%b ch=%0d d=%h want v=0 ch=3 d=d", o_valid, o_ch, o_data); end
        set_in(4'b1111, 1'b0);
        n_cmp++; if (i_ready !== 4'b0001) begin n_err++; $display("FAIL drain_ptr_kept: got %b want 0001", i_ready); end
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd0, 4'hA}) begin n_err++; $display("FAIL drain_refill: got v=%b ch=%0d d=%h want v=1 ch=0 d=a", o_valid, o_ch, o_data); end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        i_data = 16'hDCBA;
        for (int i = 0; i < 4; i++) begin
            set_in(4'b1111, 1'b1);
            n_cmp++; if (i_ready !== 4'b0001) begin n_err++; $display("FAIL fixed_i_ready[%0d]: got %b want 0001", i, i_ready); end
            tick();
            n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd0, 4'hA}) begin n_err++; $display("FAIL fixed_word[%0d]: got v=%b ch=%0d d=%h want v=1 ch=0 d=a", i, o_valid, o_ch, o_data); end
        end
        set_in(4'b1010, 1'b1);
        tick();
        n_cmp++; if ({o_valid, o_ch, o_data} !== {1'b1, 2'd1, 4'hB}) begin n_err++; $display("FAIL fixed_1010: got v=%b ch=%0d d=%h want v=1 ch=1 d=b", o_valid, o_ch, o_data); end
        set_in(4'b0000, 1'b1);
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
`ifdef MUX_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
        test_sparse_wrap();
        test_backpressure();
        test_drain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
